wta_inhibit_scheduler: RTL

//  Winner-take-all scheduler for the 10-neuron output layer. It samples the

---
 rtl/wta_if.sv | 33 +++
 rtl/wta_inhibit_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wta_if.sv
// Signal bundle between the output-layer neuron array and the WTA scheduler.
// The scheduler connects to the slave modport. The neuron/learning side connects to the master modport.
interface wta_if #(
  parameter int N_NEURON = 10,
  parameter int ID_W     = 4,
  parameter int CNT_W    = 8
);
  logic                enable;
  logic                learn;
  logic [N_NEURON-1:0] spike;
  logic [N_NEURON-1:0] inhibition;
  logic [N_NEURON-1:0] learn_grant;
  logic [ID_W-1:0]     winner_id;
  logic                winner_valid;
  logic                busy;
  logic [CNT_W-1:0]    drop_cnt;
  logic [1:0]          state_dbg;
  logic [ID_W-1:0]     ptr_dbg;

  // winner_valid qualifies winner_id for exactly one cycle. There is no ready:
  // the consumer must take the grant in that cycle. spike is level-sampled and never back-pressured.
  modport master (
    output enable, learn, spike,
    input  inhibition, learn_grant, winner_id, winner_valid, busy, drop_cnt,
    input  state_dbg, ptr_dbg
  );

  modport slave (
    input  enable, learn, spike,
    output inhibition, learn_grant, winner_id, winner_valid, busy, drop_cnt,
    output state_dbg, ptr_dbg
  );
endinterface

// File: rtl/wta_inhibit_scheduler.sv
// Winner-take-all scheduler: round-robin grant of one spiking neuron, then a timed
// lateral-inhibition window and an all-neuron recovery window. Learning is gated to the winner.
module wta_inhibit_scheduler #(
  parameter int N_NEURON       = 10,
  parameter int ID_W           = 4,
  parameter int INHIB_CYCLES   = 16,
  parameter int RECOVER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input logic  clk,
  input logic  rst,
  wta_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, INHIBIT = 2'd1, RECOVER = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0]    drop_q, drop_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt;
  logic [ID_W-1:0]     id_q, id_nxt;
  logic [ID_W-1:0]     win, hi_win, lo_win;
  logic                hi_found, grant;
  logic                learn_lat, learn_lat_nxt;
  logic [N_NEURON-1:0] win_oh, inh_q, inh_nxt, lg_q, lg_nxt;
  logic                valid_q, busy_q;

  // Lowest set bit at or above ptr, otherwise the lowest set bit overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = N_NEURON - 1; j >= 0; j--) begin
      if (bus.spike[j]) begin
        lo_win = ID_W'(j);
        if (ID_W'(j) >= ptr) begin
          hi_found = 1'b1;
          hi_win   = ID_W'(j);
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    learn_lat_nxt = learn_lat;
    id_nxt        = id_q;
    grant         = 1'b0;
    drop_nxt      = drop_q;
    unique case (state)
      IDLE: begin
        if (bus.enable && (|bus.spike)) begin
          grant         = 1'b1;
          state_nxt     = INHIBIT;
          cnt_nxt       = CNT_W'(INHIB_CYCLES - 1);
          ptr_nxt       = (win == ID_W'(N_NEURON - 1)) ? '0 : win + 1'b1;
          learn_lat_nxt = bus.learn;
          id_nxt        = win;
        end
      end
      INHIBIT: begin
        if (cnt == '0) begin
          if (RECOVER_CYCLES > 0) begin
            state_nxt = RECOVER;
            cnt_nxt   = CNT_W'(RECOVER_CYCLES - 1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if ((state != IDLE) && (|bus.spike) && (drop_q != '1)) drop_nxt = drop_q + 1'b1;

    // Outputs are registered from the next state so they line up with the state they describe.
    win_oh  = N_NEURON'(1) << id_nxt;
    inh_nxt = '0;
    lg_nxt  = '0;
    unique case (state_nxt)
      INHIBIT: begin
        inh_nxt = ~win_oh;
        if (learn_lat_nxt) lg_nxt = win_oh;
      end
      RECOVER: inh_nxt = '1;
      default: inh_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      learn_lat <= 1'b0;
      id_q      <= '0;
      drop_q    <= '0;
      inh_q     <= '0;
      lg_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      learn_lat <= learn_lat_nxt;
      id_q      <= id_nxt;
      drop_q    <= drop_nxt;
      inh_q     <= inh_nxt;
      lg_q      <= lg_nxt;
      valid_q   <= grant;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  assign bus.inhibition   = inh_q;
  assign bus.learn_grant  = lg_q;
  assign bus.winner_id    = id_q;
  assign bus.winner_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.drop_cnt     = drop_q;
  assign bus.state_dbg    = state;
  assign bus.ptr_dbg      = ptr;
endmodule
